// File: rtl/imem_port_if.sv
// Bundle of the fetch, loader and instruction-RAM signals around imem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM environment.
interface imem_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-port instruction RAM between fetch and the debug loader, loader first
// with a starvation guard for fetch. Optional counters under IMEM_ARB_PERF_EN.
module imem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  imem_port_if.slave  bus
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0] f_stall_cnt,
  output logic [31:0] d_grant_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       gnt_f;
  logic       gnt_d;
  logic       vld_f_p1;
  logic       vld_d_p1;

  // Grants are masked while reset is held so no access leaks out during reset.
  always_comb begin
    gnt_f = reset_n & bus.f_req & (~bus.d_req | (starve_cnt == LIMIT));
    gnt_d = reset_n & bus.d_req & ~gnt_f;
  end

  always_comb begin
    bus.f_gnt     = gnt_f;
    bus.d_gnt     = gnt_d;
    bus.mem_en    = gnt_f | gnt_d;
    bus.mem_we    = gnt_d & bus.d_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_f) begin
      bus.mem_addr = bus.f_addr;
    end else if (gnt_d) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!bus.f_req || gnt_f) begin
      starve_nxt = '0;
    end else if (gnt_d) begin
      starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // ---- stage p1: owner tag of the read issued last cycle ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_f_p1 <= 1'b0;
      vld_d_p1 <= 1'b0;
    end else begin
      vld_f_p1 <= gnt_f;
      vld_d_p1 <= gnt_d & ~bus.d_we;
    end
  end

  always_comb begin
    bus.f_rvalid = vld_f_p1;
    bus.d_rvalid = vld_d_p1;
    bus.f_rdata  = vld_f_p1 ? bus.mem_rdata : '0;
    bus.d_rdata  = vld_d_p1 ? bus.mem_rdata : '0;
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_stall_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      if (bus.f_req && !gnt_f) f_stall_cnt <= f_stall_cnt + 32'd1;
      if (gnt_d)               d_grant_cnt <= d_grant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (expected winner, shadow memory, pending read return).
module tb_imem_port_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] f_stall_cnt;
  logic [31:0] d_grant_cnt;
`endif

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef IMEM_ARB_PERF_EN
    ,
    .f_stall_cnt (f_stall_cnt),
    .d_grant_cnt (d_grant_cnt)
`endif
  );

  // Behavioural single-port RAM with one-cycle read latency.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata    <= ram[bus.mem_addr];
    end
  end

  // Requesters must hold address/data/we while waiting for a grant.
  logic          pf_wait = 1'b0, pd_wait = 1'b0;
  logic [AW-1:0] pf_addr, pd_addr;
  logic          pd_we;
  logic [DW-1:0] pd_wdata;
  always @(negedge clk) begin
    if (reset_n) begin
      assert (!(pf_wait && bus.f_req && bus.f_addr !== pf_addr))
        else $error("fetch address changed while waiting for grant");
      assert (!(pd_wait && bus.d_req && {bus.d_we, bus.d_addr, bus.d_wdata} !== {pd_we, pd_addr, pd_wdata}))
        else $error("loader request changed while waiting for grant");
    end
    pf_wait  <= reset_n && bus.f_req && !bus.f_gnt;
    pd_wait  <= reset_n && bus.d_req && !bus.d_gnt;
    pf_addr  <= bus.f_addr;
    pd_addr  <= bus.d_addr;
    pd_we    <= bus.d_we;
    pd_wdata <= bus.d_wdata;
  end

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [DW-1:0] shadow [0:255];
  int            m_wins;
  bit            m_pf, m_pd;
  logic [DW-1:0] m_fd, m_dd;
  bit            e_f, e_d;

  task automatic model_reset();
    m_wins = 0; m_pf = 0; m_pd = 0; m_fd = '0; m_dd = '0;
  endtask

  // Loader wins unless fetch has already waited through LIM loader wins.
  task automatic predict();
    e_d = reset_n && bus.d_req && !(bus.f_req && m_wins >= LIM);
    e_f = reset_n && bus.f_req && !e_d;
  endtask

  task automatic advance();
    predict();
    @(posedge clk);
    m_pf = e_f;
    m_fd = shadow[bus.f_addr];
    m_pd = e_d && !bus.d_we;
    m_dd = shadow[bus.d_addr];
    if (e_d && bus.d_we) shadow[bus.d_addr] = bus.d_wdata;
    if (bus.f_req && e_d) m_wins = (m_wins + 1 > LIM) ? LIM : m_wins + 1;
    else                  m_wins = 0;
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    bus.f_req = 1; bus.f_addr = 8'h11;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h22; bus.d_wdata = 32'hDEAD_BEEF;
    model_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.f_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.f_rvalid, bus.d_rvalid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 000000",
               {bus.f_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.f_rvalid, bus.d_rvalid});
    end
    tests++;
    if ({bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.d_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_data got addr=%h wdata=%h frd=%h drd=%h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.d_rdata);
    end
`ifdef IMEM_ARB_PERF_EN
    tests++;
    if ({f_stall_cnt, d_grant_cnt} !== 64'd0) begin
      fails++;
      $display("FAIL reset_perf got %h/%h want 0/0", f_stall_cnt, d_grant_cnt);
    end
`endif
    reset_n = 1;
    #1;
    tests++;
    if ({bus.f_gnt, bus.d_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL release_grant got %b want 01", {bus.f_gnt, bus.d_gnt});
    end
    advance();
    idle_inputs();
    advance();
  endtask

  task automatic test_fetch_only();
    logic [DW-1:0] w [0:2];
    w[0] = 32'h2001_0001; w[1] = 32'h2002_000B; w[2] = 32'h2021_0001;
    for (int i = 0; i < 3; i++) begin
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = AW'(i); bus.d_wdata = w[i];
      advance();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.f_req = (i < 3); bus.f_addr = (i < 3) ? AW'(i) : '0;
      @(negedge clk);
      tests++;
      if ({bus.f_gnt, bus.mem_en, bus.mem_we} !== {i < 3, i < 3, 1'b0}) begin
        fails++;
        $display("FAIL fetch_gnt[%0d] got %b want %b", i, {bus.f_gnt, bus.mem_en, bus.mem_we},
                 {i < 3, i < 3, 1'b0});
      end
      tests++;
      if (i == 0) begin
        if (bus.f_rvalid !== 1'b0) begin
          fails++;
          $display("FAIL fetch_rvalid0 got %b want 0", bus.f_rvalid);
        end
      end else if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, w[i-1]}) begin
        fails++;
        $display("FAIL fetch_data[%0d] got %b/%h want 1/%h", i - 1, bus.f_rvalid, bus.f_rdata, w[i-1]);
      end
      advance();
    end
  endtask

  task automatic test_loader_wr_rd();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'd5; bus.d_wdata = 32'h2002_003F;
    @(negedge clk);
    tests++;
    if ({bus.d_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 8'd5, 32'h2002_003F}) begin
      fails++;
      $display("FAIL ld_write got gnt=%b we=%b a=%h d=%h want 1 1 05 2002003f",
               bus.d_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    advance();
    bus.d_we = 0; bus.d_wdata = '0;
    @(negedge clk);
    tests++;
    if ({bus.d_gnt, bus.mem_we, bus.d_rvalid} !== 3'b100) begin
      fails++;
      $display("FAIL ld_read_issue got %b want 100", {bus.d_gnt, bus.mem_we, bus.d_rvalid});
    end
    advance();
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({bus.d_rvalid, bus.d_rdata, bus.f_rvalid} !== {1'b1, 32'h2002_003F, 1'b0}) begin
      fails++;
      $display("FAIL ld_readback got v=%b d=%h fv=%b want 1/2002003f/0", bus.d_rvalid, bus.d_rdata, bus.f_rvalid);
    end
    advance();
    @(negedge clk);
    tests++;
    if (bus.d_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL ld_single_rvalid got %b want 0", bus.d_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] s_stall, s_dg;
    s_stall = '0; s_dg = '0;
    idle_inputs();
    advance();
    bus.f_req = 1; bus.f_addr = 8'd0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'd6; bus.d_wdata = 32'h0BAD_F00D;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
`ifdef IMEM_ARB_PERF_EN
      if (c == 0) begin s_stall = f_stall_cnt; s_dg = d_grant_cnt; end
`endif
      tests++;
      if ({bus.f_gnt, bus.d_gnt} !== ((c % 5 == 4) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL starve_cycle%0d got %b want %b", c, {bus.f_gnt, bus.d_gnt},
                 (c % 5 == 4) ? 2'b10 : 2'b01);
      end
      if (c == 5) begin
        tests++;
        if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, 32'h2001_0001}) begin
          fails++;
          $display("FAIL starve_fetch_data got %b/%h want 1/20010001", bus.f_rvalid, bus.f_rdata);
        end
      end
      advance();
    end
    @(negedge clk);
`ifdef IMEM_ARB_PERF_EN
    tests++;
    if ({f_stall_cnt - s_stall, d_grant_cnt - s_dg} !== {32'd8, 32'd8}) begin
      fails++;
      $display("FAIL perf_counts got stall=%0d dgnt=%0d want 8/8", f_stall_cnt - s_stall, d_grant_cnt - s_dg);
    end
`else
    s_stall = s_dg;
`endif
    idle_inputs();
    advance();
    advance();
  endtask

  task automatic test_reset_mid_read();
    idle_inputs();
    bus.f_req = 1; bus.f_addr = 8'd3;
    @(negedge clk);
    tests++;
    if (bus.f_gnt !== 1'b1) begin
      fails++;
      $display("FAIL midrd_issue got %b want 1", bus.f_gnt);
    end
    advance();
    reset_n = 0;
    bus.f_req = 0;
    model_reset();
    @(negedge clk);
    tests++;
    if ({bus.f_rvalid, bus.f_rdata} !== {1'b0, 32'd0}) begin
      fails++;
      $display("FAIL midrd_in_reset got %b/%h want 0/0", bus.f_rvalid, bus.f_rdata);
    end
    advance();
    @(negedge clk);
    reset_n = 1;
    advance();
    @(negedge clk);
    tests++;
    if ({bus.f_rvalid, bus.d_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL midrd_after_reset got %b want 00", {bus.f_rvalid, bus.d_rvalid});
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_addr;
    idle_inputs();
    for (int a = 0; a < 16; a++) begin
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = AW'(a); bus.d_wdata = $urandom;
      advance();
    end
    idle_inputs();
    e_f = 0; e_d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(bus.f_req && !e_f)) begin
        bus.f_req  = ($urandom_range(0, 3) != 0);
        bus.f_addr = AW'($urandom_range(0, 15));
      end
      if (!(bus.d_req && !e_d)) begin
        bus.d_req   = ($urandom_range(0, 2) == 0);
        bus.d_we    = $urandom_range(0, 1) == 1;
        bus.d_addr  = AW'($urandom_range(0, 15));
        bus.d_wdata = $urandom;
      end
      @(negedge clk);
      predict();
      exp_addr = e_f ? bus.f_addr : (e_d ? bus.d_addr : '0);
      tests++;
      if ({bus.f_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !==
          {e_f, e_d, e_f | e_d, e_d & bus.d_we, exp_addr}) begin
        fails++;
        $display("FAIL rnd_grant[%0d] got f=%b d=%b en=%b we=%b a=%h want %b %b %b %b %h", n,
                 bus.f_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr,
                 e_f, e_d, e_f | e_d, e_d & bus.d_we, exp_addr);
      end
      tests++;
      if ({bus.f_rvalid, bus.f_rdata} !== {m_pf, m_pf ? m_fd : 32'd0}) begin
        fails++;
        $display("FAIL rnd_fetch_ret[%0d] got %b/%h want %b/%h", n, bus.f_rvalid, bus.f_rdata,
                 m_pf, m_pf ? m_fd : 32'd0);
      end
      tests++;
      if ({bus.d_rvalid, bus.d_rdata} !== {m_pd, m_pd ? m_dd : 32'd0}) begin
        fails++;
        $display("FAIL rnd_load_ret[%0d] got %b/%h want %b/%h", n, bus.d_rvalid, bus.d_rdata,
                 m_pd, m_pd ? m_dd : 32'd0);
      end
      if (e_d && bus.d_we) begin
        tests++;
        if (bus.mem_wdata !== bus.d_wdata) begin
          fails++;
          $display("FAIL rnd_wdata[%0d] got %h want %h", n, bus.mem_wdata, bus.d_wdata);
        end
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_fetch_only();
    test_loader_wr_rd();
    test_starvation();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port synchronous instruction RAM (256 x 32, word addressed) between two requesters:
  - the pipeline fetch stage;
  - a debug/program loader that writes and reads back program words at run time.
- Sits between the fetch stage and the instruction memory. The memory returns read data one clock after the access.
- Arbitrates one access per cycle with fixed loader priority and an anti-starvation guard for fetch. Returns read data with an owner tag.

Parameters:
- ADDR_W, 8, word-address width (2^ADDR_W words).
- DATA_W, 32, instruction/data word width.
- STARVE_LIMIT, 4, consecutive loader wins allowed while fetch waits; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request; held with f_addr stable until f_gnt.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch access issued this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_W  fetch read data.
- d_req  in  1  loader request; held stable until d_gnt.
- d_we  in  1  loader write (1) / read (0).
- d_addr  in  ADDR_W  loader word address.
- d_wdata  in  DATA_W  loader write data.
- d_gnt  out  1  loader access issued this cycle.
- d_rvalid  out  1  loader read data valid.
- d_rdata  out  DATA_W  loader read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read access.

Behaviour:
- Grant decision is combinational from requests and the starve counter. At most one of f_gnt/d_gnt is high per cycle. A grant equals an issued RAM access that cycle.
- Priority:
  - d_req wins, unless f_req=1 and starve_cnt==STARVE_LIMIT; then fetch wins.
  - With only one request pending, that request wins.
  - With no requests: mem_en=0, mem_we=0; mem_addr/mem_wdata are don't-care but driven to 0.
- starve_cnt (4-bit register):
  - +1 when d_gnt=1 and f_req=1.
  - Cleared when f_gnt=1 or f_req=0.
  - Saturates at STARVE_LIMIT.
- RAM drive:
  - Fetch grant: mem_en=1, mem_we=0, mem_addr=f_addr.
  - Loader grant: mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata.
- Read return (registered tag pipeline, latency 1):
  - The cycle after a read grant, the owner's rvalid=1 and rdata=mem_rdata.
  - Non-owner rdata=0 and rvalid=0.
  - Loader writes never produce d_rvalid.
- Back-to-back: a new grant can issue in the same cycle a previous read returns. Full throughput is 1 access/cycle.
- Read-after-write to the same address in the following cycle returns the new data, since the write completed in the RAM the prior edge.
- Reset (async assert, sync-safe deassert by system):
  - All outputs go to 0 and starve_cnt=0.
  - An outstanding read is discarded: no rvalid after reset release for an access issued before reset.
- Illegal: changing addr/wdata/we while req=1 and not granted. Behaviour is undefined; the bench flags it as an assertion.

Optional Feature:
- Macro IMEM_ARB_PERF_EN.
- Defined:
  - Adds output port f_stall_cnt [31:0], counting cycles with f_req=1 and f_gnt=0.
  - Wraps at 2^32. Reset value 0 (async).
  - Also adds output d_grant_cnt [31:0], counting loader grants; wraps, reset 0.
- Undefined: both ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with both reqs high -> all outputs 0; release -> first grant next rising edge.
- Fetch only: f_addr 0,1,2 on consecutive cycles, RAM preloaded 0x20010001, 0x2002000B, 0x20210001 -> f_gnt=1 each cycle; f_rvalid=1 one cycle later with those words in order.
- Loader write then read: write addr 5 = 0x2002003F, then read addr 5 -> d_gnt both cycles; d_rvalid=1 once with 0x2002003F; no d_rvalid for the write.
- Starvation, STARVE_LIMIT=4: d_req and f_req held high -> d_gnt cycles 0-3, f_gnt cycle 4, d_gnt cycles 5-8, f_gnt cycle 9.
- Reset mid-read: grant fetch read of addr 3, assert reset_n=0 before the next edge -> f_rvalid stays 0 through and after reset.
- Perf (IMEM_ARB_PERF_EN): starvation scenario for 10 cycles -> f_stall_cnt=8, d_grant_cnt=8.
